// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Time-multiplexes one purely combinational ALU between two requesters.
// A requester raises req with its operands/opcode and holds req until its
// done pulse. The arbiter samples requests in IDLE and latches the winner's
// operands. It drives the ALU from those latches during EXEC and registers the
// result at the end of EXEC. It then pulses done to the winner during RESP.
// Every operation occupies the block for exactly three cycles.
//
// Conflict resolution:
//   default                  : round-robin. The requester that was not served
//                              last wins. Out of reset, requester 0 wins first.
//   ALU_SHARE_FIXED_PRIO_EN  : fixed priority. Requester 0 always wins.
//
// Ports:
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   req0/a0/b0/aluc0     requester 0 request, operands and opcode
//   done0                one-cycle pulse: rdata/rz valid for requester 0
//   req1/a1/b1/aluc1     requester 1 request, operands and opcode
//   done1                one-cycle pulse: rdata/rz valid for requester 1
//   rdata, rz            registered ALU result and zero flag; held until the
//                        next operation completes
//   busy                 high whenever the FSM is not in IDLE
//   alu_a/alu_b/alu_aluc to the shared ALU, driven from the operand latches
//   alu_s, alu_z         from the shared ALU
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   aluc0,
  output logic             done0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   aluc1,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             rz,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_aluc,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             winner;     // id of the operation in flight
  logic             grant_id;   // id that would win if sampled this cycle
  logic             any_req;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [OPW-1:0]   lat_aluc;

  assign any_req = req0 | req1;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic last_grant;   // id served by the most recently completed operation
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    grant_id = 1'b0;
    if (req0 && req1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant;
`endif
    end else if (req1) begin
      grant_id = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: clocked state uses non-blocking assignments, so every flop samples
    // the pre-edge values regardless of statement order.
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latches and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: these are plain registers, not a memory array. The ALU inputs must
    // read zero out of reset, so they are all reset explicitly.
    if (!resetn) begin
      winner   <= 1'b0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_aluc <= '0;
      rdata    <= '0;
      rz       <= 1'b0;
    end else begin
      // Operands are sampled only at the IDLE->EXEC edge. Later changes on
      // a*/b*/aluc* cannot disturb the operation in flight.
      if (state == IDLE && any_req) begin
        winner   <= grant_id;
        lat_a    <= grant_id ? a1 : a0;
        lat_b    <= grant_id ? b1 : b0;
        lat_aluc <= grant_id ? aluc1 : aluc0;
      end
      if (state == EXEC) begin
        rdata <= alu_s;
        rz    <= alu_z;
      end
    end
  end

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // Reset value 1 makes requester 0 the winner of the first conflict.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (state == RESP) begin
      last_grant <= winner;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from flops, so they clear as soon as reset asserts
  // ---------------------------------------------------------------------------
  assign alu_a    = lat_a;
  assign alu_b    = lat_b;
  assign alu_aluc = lat_aluc;
  assign busy     = (state != IDLE);
  assign done0    = (state == RESP) && !winner;
  assign done1    = (state == RESP) &&  winner;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. A behavioural ALU drives the
// alu_s/alu_z inputs. A transaction-level model tracks the following:
//   - which request is granted at each sampling edge;
//   - when the block is free again (three cycles per operation);
//   - what the result of each granted operation must be.
// Directed scenarios compare against hand-derived constants. The randomized
// scenario compares every output on every cycle against the model.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W   = 32;
  localparam int OPW = 4;

  logic           clock;
  logic           resetn;
  logic           req0;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic [OPW-1:0] aluc0;
  logic           done0;
  logic           req1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic [OPW-1:0] aluc1;
  logic           done1;
  logic [W-1:0]   rdata;
  logic           rz;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_aluc;
  logic [W-1:0]   alu_s;
  logic           alu_z;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .aluc0    (aluc0),
    .done0    (done0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .aluc1    (aluc1),
    .done1    (done1),
    .rdata    (rdata),
    .rz       (rz),
    .busy     (busy),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_aluc (alu_aluc),
    .alu_s    (alu_s),
    .alu_z    (alu_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA (shift b by a).
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [OPW-1:0] op);
    logic [W-1:0] r;
    casez (op)
      4'b?000: r = a + b;
      4'b?100: r = a - b;
      4'b?001: r = a & b;
      4'b?101: r = a | b;
      4'b?010: r = a ^ b;
      4'b?110: r = {b[15:0], 16'h0000};
      4'b0011: r = b << a[4:0];
      4'b0111: r = b >> a[4:0];
      4'b1111: r = $unsigned($signed(b) >>> a[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_s = alu_ref(alu_a, alu_b, alu_aluc);
  assign alu_z = (alu_s == '0);

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  int           edge_cnt = 0;
  bit           m_have_op;
  int           m_grant_edge;
  bit           m_id;
  logic [W-1:0] m_a, m_b, m_rdata;
  logic [3:0]   m_c;
  bit           m_rz;
  bit           m_last;

  task automatic model_reset();
    m_have_op    = 1'b0;
    m_grant_edge = -10;
    m_id         = 1'b0;
    m_a = '0; m_b = '0; m_c = '0;
    m_rdata = '0; m_rz = 1'b0;
    m_last  = 1'b1;
  endtask

  // Advance one clock edge. The model updates from the inputs that were
  // present at that edge. Returns #1 after the edge, where inputs may change.
  task automatic tick();
    logic r0, r1, rn, id;
    logic [W-1:0] sa0, sb0, sa1, sb1;
    logic [3:0] sc0, sc1;
    bit free;
    r0 = req0; r1 = req1; rn = resetn;
    sa0 = a0; sb0 = b0; sc0 = aluc0;
    sa1 = a1; sb1 = b1; sc1 = aluc1;
    @(posedge clock);
    #1;
    edge_cnt++;
    if (!rn) begin
      model_reset();
    end else begin
      if (m_have_op && edge_cnt == m_grant_edge + 1) begin
        m_rdata = alu_ref(m_a, m_b, m_c);
        m_rz    = (m_rdata == '0);
      end
      free = !m_have_op || (edge_cnt >= m_grant_edge + 3);
      if (free && (r0 || r1)) begin
        if (r0 && r1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
          id = 1'b0;
`else
          id = ~m_last;
`endif
        end else begin
          id = r1;
        end
        m_have_op    = 1'b1;
        m_grant_edge = edge_cnt;
        m_id         = id;
        m_last       = id;
        m_a = id ? sa1 : sa0;
        m_b = id ? sb1 : sb0;
        m_c = id ? sc1 : sc0;
      end
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; a0 = '0; b0 = '0; aluc0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0; aluc1 = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    tick();
    tick();
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done0: got %b expected 0", done0); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b expected 0", done1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (rz !== 1'b0) begin n_fail++; $display("FAIL reset_rz: got %b expected 0", rz); end
    n_checks++; if (alu_aluc !== 4'h0) begin n_fail++; $display("FAIL reset_alu_aluc: got %h expected 0", alu_aluc); end
    n_checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu_ab: got %h/%h expected 0/0", alu_a, alu_b); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; aluc0 = 4'b0000;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_exec: got %b expected 1", busy); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL single_done0_early: got %b expected 0", done0); end
    tick();
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL single_done0: got %b expected 1", done0); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL single_done1: got %b expected 0", done1); end
    n_checks++; if (rdata !== 32'd8) begin n_fail++; $display("FAIL single_rdata: got %h expected 8", rdata); end
    n_checks++; if (rz !== 1'b0) begin n_fail++; $display("FAIL single_rz: got %b expected 0", rz); end
    req0 = 1'b0;
    tick();
    n_checks++; if (done0 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got done0=%b busy=%b expected 0/0", done0, busy); end
    n_checks++; if (rdata !== 32'd8) begin n_fail++; $display("FAIL single_rdata_hold: got %h expected 8", rdata); end
  endtask

  task automatic test_zero_flag();
    req1 = 1'b1; a1 = 32'd7; b1 = 32'd7; aluc1 = 4'b0100;
    tick();
    tick();
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL zero_done1: got %b expected 1", done1); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL zero_done0: got %b expected 0", done0); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL zero_rdata: got %h expected 0", rdata); end
    n_checks++; if (rz !== 1'b1) begin n_fail++; $display("FAIL zero_rz: got %b expected 1", rz); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    int           seq[$];
    logic [W-1:0] res[$];
    int           exp_seq[4];
    logic [W-1:0] exp_res[4];
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
    exp_res = '{32'h0000F000, 32'h0000F000, 32'h0000F000, 32'h0000F000};
`else
    exp_seq = '{0, 1, 0, 1};
    exp_res = '{32'h0000F000, 32'h00000003, 32'h0000F000, 32'h00000003};
`endif
    resetn = 1'b0;
    model_reset();
    tick();
    resetn = 1'b1;
    req0 = 1'b1; a0 = 32'h0000F0F0; b0 = 32'h0000FF00; aluc0 = 4'b0001;
    req1 = 1'b1; a1 = 32'h00000001; b1 = 32'h00000002; aluc1 = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++; if (done0 && done1) begin n_fail++; $display("FAIL conflict_exclusive: got done0=%b done1=%b expected not both", done0, done1); end
      if (done0) begin seq.push_back(0); res.push_back(rdata); end
      if (done1) begin seq.push_back(1); res.push_back(rdata); end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_checks++; if (seq.size() != 4) begin n_fail++; $display("FAIL conflict_count: got %0d expected 4", seq.size()); end
    if (seq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (seq[i] != exp_seq[i]) begin n_fail++; $display("FAIL conflict_order[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]); end
        n_checks++; if (res[i] !== exp_res[i]) begin n_fail++; $display("FAIL conflict_rdata[%0d]: got %h expected %h", i, res[i], exp_res[i]); end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_operand_stability();
    req0 = 1'b1; a0 = 32'd4; b0 = 32'h80000000; aluc0 = 4'b1111;
    tick();
    n_checks++; if (alu_a !== 32'd4 || alu_aluc !== 4'b1111) begin n_fail++; $display("FAIL stable_alu_in: got %h/%h expected 4/f", alu_a, alu_aluc); end
    a0 = 32'd8;
    tick();
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL stable_done0: got %b expected 1", done0); end
    n_checks++; if (rdata !== 32'hF8000000) begin n_fail++; $display("FAIL stable_rdata: got %h expected f8000000", rdata); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    req0 = 1'b1; a0 = 32'd100; b0 = 32'd23; aluc0 = 4'b0000;
    tick();
    resetn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b%b expected 00", done0, done1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (rdata !== 32'h0 || rz !== 1'b0) begin n_fail++; $display("FAIL midrst_result: got %h/%b expected 0/0", rdata, rz); end
    n_checks++; if (alu_aluc !== 4'h0 || alu_a !== 32'h0) begin n_fail++; $display("FAIL midrst_alu_in: got %h/%h expected 0/0", alu_aluc, alu_a); end
    tick();
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b expected 0", done0); end
    resetn = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1 || done0 !== 1'b0) begin n_fail++; $display("FAIL midrst_regrant: got busy=%b done0=%b expected 1/0", busy, done0); end
    tick();
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL midrst_done0: got %b expected 1", done0); end
    n_checks++; if (rdata !== 32'd123) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 7b", rdata); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_drop_req();
    req1 = 1'b1; a1 = 32'hFFFF0000; b1 = 32'h0000FFFF; aluc1 = 4'b0010;
    tick();
    req1 = 1'b0;
    tick();
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL drop_done1: got %b expected 1", done1); end
    n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL drop_rdata: got %h expected ffffffff", rdata); end
    tick();
  endtask

  task automatic test_random();
    logic           e_done0, e_done1, e_busy;
    logic [W-1:0]   e_a, e_b;
    logic [OPW-1:0] e_c;
    for (int i = 0; i < 3000; i++) begin
      a0 = $urandom; b0 = $urandom; aluc0 = 4'($urandom);
      a1 = $urandom; b1 = $urandom; aluc1 = 4'($urandom);
      if ($urandom_range(0, 7) == 0) b0 = a0;
      if ($urandom_range(0, 7) == 0) a1 = 32'($urandom_range(0, 40));
      if (!req0 && $urandom_range(0, 2) == 0) req0 = 1'b1;
      if (!req1 && $urandom_range(0, 2) == 0) req1 = 1'b1;
      tick();
      e_busy  = m_have_op && (edge_cnt - m_grant_edge) <= 1;
      e_done0 = m_have_op && (edge_cnt == m_grant_edge + 1) && !m_id;
      e_done1 = m_have_op && (edge_cnt == m_grant_edge + 1) &&  m_id;
      e_a = m_a; e_b = m_b; e_c = m_c;
      n_checks++; if (done0 !== e_done0) begin n_fail++; $display("FAIL rand_done0 @%0d: got %b expected %b", i, done0, e_done0); end
      n_checks++; if (done1 !== e_done1) begin n_fail++; $display("FAIL rand_done1 @%0d: got %b expected %b", i, done1, e_done1); end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rand_busy @%0d: got %b expected %b", i, busy, e_busy); end
      n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata @%0d: got %h expected %h", i, rdata, m_rdata); end
      n_checks++; if (rz !== m_rz) begin n_fail++; $display("FAIL rand_rz @%0d: got %b expected %b", i, rz, m_rz); end
      n_checks++; if (alu_a !== e_a || alu_b !== e_b || alu_aluc !== e_c) begin
        n_fail++;
        $display("FAIL rand_alu_in @%0d: got %h/%h/%h expected %h/%h/%h", i, alu_a, alu_b, alu_aluc, e_a, e_b, e_c);
      end
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_zero_flag();
    test_conflict();
    test_operand_stability();
    test_reset_mid_op();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
